// File: rtl/sp_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arbiter_if
// Description : One request/grant port into the single-port RAM arbiter.
//               The master side drives the request and its payload. The slave
//               side (the arbiter) returns the grant, the response strobe and
//               the read data.
//   req    master->slave  request, held stable until gnt
//   addr   master->slave  byte address (ADDR_WIDTH+2 bits)
//   we     master->slave  1 = write
//   be     master->slave  byte enables
//   wdata  master->slave  write data
//   gnt    slave->master  grant, combinational in the request cycle
//   rvalid slave->master  response strobe, one cycle after gnt
//   rdata  slave->master  read data, meaningful only while rvalid = 1
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH+1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_arbiter
// Description : Two-master round-robin front end for a single-port word SRAM.
//               Port 0 is the instruction-fetch port and port 1 is the data
//               port. The module turns byte addresses into word addresses,
//               drives the RAM controls, and sends the 1-cycle-latency read
//               data back to the granted port with an rvalid strobe.
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   p0, p1      request/grant ports (slave modport)
//   ram_en_o    RAM access enable
//   ram_addr_o  RAM word address
//   ram_we_o    RAM write enable
//   ram_be_o    RAM byte enables
//   ram_wdata_o RAM write data
//   ram_rdata_i RAM read data, registered in the RAM
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_ram_arbiter_if.slave       p0,
  sp_ram_arbiter_if.slave       p1,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  // rr_q is the port that wins the next conflict.
  logic       rr_q, rr_d;
  logic [1:0] rvalid_q;
  logic       gnt0, gnt1;

  // Bits [1:0] of the byte address are dropped on purpose. The byte lane is
  // selected only by be.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p0.addr[1:0], p1.addr[1:0]};

  // Grants are gated with rst_n so the RAM sees no access while reset is held.
  always_comb begin
    gnt0 = rst_n & p0.req & (~p1.req | ~rr_q);
    gnt1 = rst_n & p1.req & (~p0.req |  rr_q);
  end

  // The port that was not granted gets priority next. With no grant, rr holds.
  always_comb begin
    rr_d = rr_q;
    if (gnt0) begin
      rr_d = 1'b1;
    end else if (gnt1) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      rvalid_q <= 2'b00;
    end else begin
      rr_q     <= rr_d;
      rvalid_q <= {gnt1, gnt0};
    end
  end

  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;

  // With no grant, the address and data muxes fall through to port 0. we and
  // be are forced to 0 so an idle cycle can never write.
  always_comb begin
    ram_en_o    = gnt0 | gnt1;
    ram_addr_o  = gnt1 ? p1.addr[ADDR_WIDTH+1:2] : p0.addr[ADDR_WIDTH+1:2];
    ram_wdata_o = gnt1 ? p1.wdata : p0.wdata;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0000;
    if (gnt0) begin
      ram_we_o = p0.we;
      ram_be_o = p0.be;
    end else if (gnt1) begin
      ram_we_o = p1.we;
      ram_be_o = p1.be;
    end
  end

  // The RAM output already lines up with rvalid, so it goes to both ports
  // without another register. Each port qualifies it with its own rvalid.
  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign p0.rdata  = ram_rdata_i;
  assign p1.rdata  = ram_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_ram_arbiter
// Description : Self-checking bench for sp_ram_arbiter. It pairs a behavioural
//               RAM with a reference memory, a vector table and a response
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata, ram_rdata;

  sp_ram_arbiter_if #(.ADDR_WIDTH(AW)) m0 ();
  sp_ram_arbiter_if #(.ADDR_WIDTH(AW)) m1 ();

  sp_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0          (m0),
    .p1          (m1),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 2) return 32'h11223344;
    if (i == 5) return 32'hDEADBEEF;
    return 32'h10000000 + i * 32'h00000101;
  endfunction

  // Behavioural single-port RAM with a registered read.
  logic [31:0] mem [0:(1<<AW)-1];
  bit          loaded;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we)
        for (int k = 0; k < 4; k++)
          if (ram_be[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  // Reference memory, maintained by the bench from the expected grants.
  logic [31:0] ref_mem [0:(1<<AW)-1];

  typedef struct {
    logic r0; logic [AW+1:0] a0; logic w0; logic [3:0] b0; logic [31:0] d0;
    logic r1; logic [AW+1:0] a1; logic w1; logic [3:0] b1; logic [31:0] d1;
    logic [1:0] eg;
  } vec_t;

  typedef struct {
    int          port;
    logic        is_rd;
    logic [31:0] data;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
      input logic r0, input logic [AW+1:0] a0, input logic w0, input logic [3:0] b0,
      input logic [31:0] d0,
      input logic r1, input logic [AW+1:0] a1, input logic w1, input logic [3:0] b1,
      input logic [31:0] d1, input logic [1:0] eg);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.w0 = w0; v.b0 = b0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.w1 = w1; v.b1 = b1; v.d1 = d1;
    v.eg = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    m0.req = v.r0; m0.addr = v.a0; m0.we = v.w0; m0.be = v.b0; m0.wdata = v.d0;
    m1.req = v.r1; m1.addr = v.a1; m1.we = v.w1; m1.be = v.b1; m1.wdata = v.d1;
  endtask

  task automatic ref_access(input int port, input vec_t v);
    sb_t             e;
    logic [AW-1:0]   wa;
    logic            w;
    logic [3:0]      b;
    logic [31:0]     d;
    wa = (port == 0) ? v.a0[AW+1:2] : v.a1[AW+1:2];
    w  = (port == 0) ? v.w0 : v.w1;
    b  = (port == 0) ? v.b0 : v.b1;
    d  = (port == 0) ? v.d0 : v.d1;
    e.port  = port;
    e.is_rd = !w;
    e.data  = ref_mem[wa];
    sbq.push_back(e);
    if (w)
      for (int k = 0; k < 4; k++)
        if (b[k]) ref_mem[wa][8*k +: 8] = d[8*k +: 8];
  endtask

  // One cycle: drive the inputs, then check the combinational outputs and the
  // responses to last cycle's grants. The check runs on the falling edge.
  task automatic step(input vec_t v);
    logic [1:0]  exp_rv;
    sb_t         e;
    logic [31:0] exp_wd;
    logic [AW-1:0] exp_a;
    logic        exp_we;
    logic [3:0]  exp_be;
    drive(v);
    @(negedge clk);
    exp_rv = 2'b00;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      exp_rv[e.port] = 1'b1;
      if (e.is_rd) chk($sformatf("rdata_p%0d", e.port),
                       (e.port == 0) ? m0.rdata : m1.rdata, e.data);
    end
    chk("p0_rvalid", {31'd0, m0.rvalid}, {31'd0, exp_rv[0]});
    chk("p1_rvalid", {31'd0, m1.rvalid}, {31'd0, exp_rv[1]});
    chk("gnt", {30'd0, m1.gnt, m0.gnt}, {30'd0, v.eg});
    exp_a  = v.eg[1] ? v.a1[AW+1:2] : v.a0[AW+1:2];
    exp_wd = v.eg[1] ? v.d1 : v.d0;
    exp_we = v.eg[0] ? v.w0 : (v.eg[1] ? v.w1 : 1'b0);
    exp_be = v.eg[0] ? v.b0 : (v.eg[1] ? v.b1 : 4'b0000);
    chk("ram_en",    {31'd0, ram_en}, {31'd0, |v.eg});
    chk("ram_addr",  {24'd0, ram_addr}, {24'd0, exp_a});
    chk("ram_we",    {31'd0, ram_we}, {31'd0, exp_we});
    chk("ram_be",    {28'd0, ram_be}, {28'd0, exp_be});
    chk("ram_wdata", ram_wdata, exp_wd);
    if (v.eg[0]) ref_access(0, v);
    if (v.eg[1]) ref_access(1, v);
    @(posedge clk);
    #1;
  endtask

  // Checks that hold for every cycle spent in reset.
  task automatic reset_cycle();
    @(negedge clk);
    chk("rst_gnt",    {30'd0, m1.gnt, m0.gnt}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_rvalid", {30'd0, m1.rvalid, m0.rvalid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] F = 32'hF;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    // Both ports request during reset, and neither may be granted.
    drive(mk(1, 10'h004, 0, 4'hF, 0, 1, 10'h008, 0, 4'hF, 0, 2'b00));
    repeat (3) reset_cycle();
    rst_n = 1'b1;

    // Idle: the address and wdata muxes follow port 0.
    repeat (4) tbl.push_back(mk(0, 10'h3FC, 0, 4'hF, 32'h55, 0, 10'h01C, 1, 4'hF, 32'h66, 2'b00));
    tbl.push_back(mk(1, 10'h017, 0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01));        // word 5, low bits dropped
    tbl.push_back(mk(1, 10'h014, 0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01));        // 0xDEADBEEF
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 10'h008, 1, 4'b0010, 32'h0000AB00, 2'b10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 10'h008, 0, 4'hF, 0, 2'b10));        // 0x1122AB44
    for (int i = 0; i < 6; i++)                                             // rr is 0 here
      tbl.push_back(mk(1, 10'h00C, 0, 4'hF, 0, 1, 10'h010, 0, 4'hF, 0, (i % 2 == 0) ? 2'b01 : 2'b10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 10'h018, 0, 4'hF, 0, 2'b10));        // p1 alone, rr -> 0
    tbl.push_back(mk(1, 10'h020, 0, 4'hF, 0, 1, 10'h018, 0, 4'hF, 0, 2'b01));
    tbl.push_back(mk(1, 10'h020, 0, 4'hF, 0, 1, 10'h018, 0, 4'hF, 0, 2'b10));
    // A write and a read to the same word in one cycle are serialized.
    tbl.push_back(mk(1, 10'h01C, 1, 4'hF, 32'hCAFEF00D, 1, 10'h01C, 0, 4'hF, 0, 2'b01));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 10'h01C, 0, 4'hF, 0, 2'b10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Reset one cycle after a grant drops the pending response.
    step(mk(0, 0, 0, 0, 0, 1, 10'h030, 0, 4'hF, 0, 2'b10));                // leaves rr = 0
    step(mk(1, 10'h024, 0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b01));                // rr -> 1
    rst_n = 1'b0;
    sbq.delete();
    drive(mk(1, 10'h024, 0, 4'hF, 0, 1, 10'h028, 0, 4'hF, 0, 2'b00));
    repeat (2) reset_cycle();
    rst_n = 1'b1;
    // rr is 0 again after reset, so the conflicts alternate from port 0.
    for (int i = 0; i < 6; i++)
      step(mk(1, 10'h024, 0, 4'hF, 0, 1, 10'h028, 0, 4'hF, 0, (i % 2 == 0) ? 2'b01 : 2'b10));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
